// File: rtl/enclave_pkg.sv
// Shared types and field/bit positions for the enclave command front end.
// Instruction layout and status register map are defined here once.
package enclave_pkg;

   typedef enum logic [1:0] {
      OP_ENC = 2'b00,
      OP_DEC = 2'b01,
      OP_ADD = 2'b10,
      OP_MUL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam int OP_LSB    = 0;
   localparam int OP_W      = 2;
   localparam int SRC0_LSB  = 2;
   localparam int SRC1_LSB  = 11;
   localparam int DST_LSB   = 20;
   localparam int START_BIT = 31;
   localparam int ENTRY_W   = 29;

   localparam int ST_BUSY     = 0;
   localparam int ST_EMPTY    = 1;
   localparam int ST_FULL     = 2;
   localparam int ST_OVF      = 3;
   localparam int ST_CNT_LSB  = 4;
   localparam int ST_CNT_W    = 3;
   localparam int ST_DONE_LSB = 8;
   localparam int ST_DONE_W   = 8;

endpackage

// File: rtl/enclave_cmd_dispatch_if.sv
// Wishbone slave bus plus the command handshake towards the compute core.
// slave = dispatcher view, master = SoC/core view.
interface enclave_cmd_dispatch_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  wbs_stb_i;
   logic                  wbs_cyc_i;
   logic                  wbs_we_i;
   logic [3:0]            wbs_sel_i;
   logic [31:0]           wbs_adr_i;
   logic [31:0]           wbs_dat_i;
   logic                  wbs_ack_o;
   logic [31:0]           wbs_dat_o;
   logic                  cmd_valid_o;
   logic                  cmd_ready_i;
   logic [1:0]            cmd_op_o;
   logic [ADDR_WIDTH-1:0] cmd_src0_o;
   logic [ADDR_WIDTH-1:0] cmd_src1_o;
   logic [ADDR_WIDTH-1:0] cmd_dst_o;
   logic                  core_done_i;
   logic                  busy_o;
   logic                  irq_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  cmd_ready_i, core_done_i,
      output wbs_ack_o, wbs_dat_o, cmd_valid_o, cmd_op_o, cmd_src0_o,
      output cmd_src1_o, cmd_dst_o, busy_o, irq_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output cmd_ready_i, core_done_i,
      input  wbs_ack_o, wbs_dat_o, cmd_valid_o, cmd_op_o, cmd_src0_o,
      input  cmd_src1_o, cmd_dst_o, busy_o, irq_o
   );

endinterface

// File: rtl/enclave_cmd_fifo.sv
// Synchronous instruction FIFO; head is presented combinationally on dout.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module enclave_cmd_fifo #(
   parameter int WIDTH = 29,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/enclave_cmd_dispatch.sv
// Wishbone command front end: decodes instruction writes, queues them and
// issues one command at a time to the compute core, counting completions.
//   state | meaning
//   IDLE  | nothing in flight; pops the FIFO head as soon as one exists
//   ISSUE | cmd_valid_o high, payload held until the core takes it
//   WAIT  | command accepted, waiting for the core_done_i pulse
module enclave_cmd_dispatch
   import enclave_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 9,
   parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
   parameter logic [31:0] STATUS_ADDR = 32'h3000_0800,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n,
   enclave_cmd_dispatch_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e                 state, state_d;
   logic                   ack_q, armed, overflow, irq_q;
   logic [31:0]            dat_q, last_word, status, rd_data;
   logic [ST_DONE_W-1:0]   done_cnt;
   op_e                    cmd_op;
   logic [ADDR_WIDTH-1:0]  cmd_src0, cmd_src1, cmd_dst;

   logic                   wb_req, op_hit, st_hit, ack_rise, op_wr_cyc;
   logic                   enq_req, push, drop, pop, ovf_clr, done_evt;
   logic                   full, empty;
   logic [CNT_W-1:0]       count;
   logic [ENTRY_W-1:0]     head;

   assign wb_req    = bus.wbs_stb_i & bus.wbs_cyc_i;
   assign op_hit    = (bus.wbs_adr_i == OPCODE_ADDR);
   assign st_hit    = (bus.wbs_adr_i == STATUS_ADDR);
   assign ack_rise  = wb_req & (op_hit | st_hit) & ~ack_q;
   assign op_wr_cyc = wb_req & bus.wbs_we_i & op_hit;

   // armed only re-arms once the write goes away, so a held strobe pushes once
   assign enq_req  = ack_rise & op_wr_cyc & (bus.wbs_sel_i == 4'hF)
                   & bus.wbs_dat_i[START_BIT] & armed;
   assign push     = enq_req & (~full | pop);
   assign drop     = enq_req & full & ~pop;
   assign ovf_clr  = ack_rise & st_hit & bus.wbs_we_i & bus.wbs_dat_i[ST_OVF];
   assign done_evt = (state == WAIT) & bus.core_done_i;

   enclave_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n),
      .push  (push),
      .pop   (pop),
      .din   (bus.wbs_dat_i[ENTRY_W-1:0]),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: if (bus.cmd_ready_i) state_d = WAIT;
         WAIT:  if (bus.core_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      status                                = '0;
      status[ST_BUSY]                       = (state != IDLE);
      status[ST_EMPTY]                      = empty;
      status[ST_FULL]                       = full;
      status[ST_OVF]                        = overflow;
      status[ST_CNT_LSB +: ST_CNT_W]        = ST_CNT_W'(count);
      status[ST_DONE_LSB +: ST_DONE_W]      = done_cnt;
   end

   assign rd_data = op_hit ? last_word : status;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         armed     <= 1'b1;
         overflow  <= 1'b0;
         last_word <= '0;
      end else begin
         ack_q <= ack_rise;
         dat_q <= (ack_rise & ~bus.wbs_we_i) ? rd_data : '0;
         if (enq_req)         armed <= 1'b0;
         else if (!op_wr_cyc) armed <= 1'b1;
         if (drop)            overflow <= 1'b1;
         else if (ovf_clr)    overflow <= 1'b0;
         if (push)            last_word <= bus.wbs_dat_i;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state    <= IDLE;
         cmd_op   <= OP_ENC;
         cmd_src0 <= '0;
         cmd_src1 <= '0;
         cmd_dst  <= '0;
         irq_q    <= 1'b0;
         done_cnt <= '0;
      end else begin
         state <= state_d;
         if (pop) begin
            cmd_op   <= op_e'(head[OP_LSB +: OP_W]);
            cmd_src0 <= head[SRC0_LSB +: ADDR_WIDTH];
            cmd_src1 <= head[SRC1_LSB +: ADDR_WIDTH];
            cmd_dst  <= head[DST_LSB +: ADDR_WIDTH];
         end
         irq_q <= done_evt;
         if (done_evt) done_cnt <= done_cnt + 1'b1;
      end
   end

   assign bus.wbs_ack_o   = ack_q;
   assign bus.wbs_dat_o   = dat_q;
   assign bus.cmd_valid_o = (state == ISSUE);
   assign bus.cmd_op_o    = cmd_op;
   assign bus.cmd_src0_o  = cmd_src0;
   assign bus.cmd_src1_o  = cmd_src1;
   assign bus.cmd_dst_o   = cmd_dst;
   assign bus.busy_o      = (state != IDLE);
   assign bus.irq_o       = irq_q;

endmodule

// File: tb/tb_enclave_cmd_dispatch.sv
// Bench for enclave_cmd_dispatch: directed steps followed by a randomized
// phase, checked against a queue-based transaction model.
module tb_enclave_cmd_dispatch;
   localparam logic [31:0] OPC = 32'h3000_0000;
   localparam logic [31:0] STA = 32'h3000_0800;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   enclave_cmd_dispatch_if #(.ADDR_WIDTH(9)) bus ();

   enclave_cmd_dispatch #(
      .ADDR_WIDTH  (9),
      .OPCODE_ADDR (OPC),
      .STATUS_ADDR (STA),
      .FIFO_DEPTH  (4)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_n (rst_n),
      .bus      (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // transaction-level model: pending queue, one in-flight slot, counters
   logic [31:0] mq[$];
   logic [31:0] cur_m;
   bit          infl_m;
   bit          ovf_m;
   int          done_m;
   logic [31:0] last_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_payload(input logic [31:0] wd);
      int op, s0, s1, ds;
      op = int'(wd % 4);
      s0 = int'((wd / 4) % 512);
      s1 = int'((wd / 2048) % 512);
      ds = int'((wd / 1048576) % 512);
      return 32'(op + s0 * 4 + s1 * 2048 + ds * 1048576);
   endfunction

   function automatic logic [31:0] obs_payload();
      return {3'b000, bus.cmd_dst_o, bus.cmd_src1_o, bus.cmd_src0_o, bus.cmd_op_o};
   endfunction

   function automatic logic [31:0] exp_status();
      return 32'(infl_m) + 32'(mq.size() == 0) * 2 + 32'(mq.size() == 4) * 4
           + 32'(ovf_m) * 8 + 32'(mq.size()) * 16 + 32'(done_m % 256) * 256;
   endfunction

   task automatic model_write(input logic [31:0] wd, input logic [3:0] sl);
      if (sl == 4'hF && wd[31]) begin
         if (mq.size() == 4) ovf_m = 1'b1;
         else begin
            mq.push_back(wd);
            last_m = wd;
         end
      end
   endtask

   task automatic model_settle();
      if (!infl_m && mq.size() > 0) begin
         cur_m  = mq.pop_front();
         infl_m = 1'b1;
      end
   endtask

   task automatic model_done();
      if (infl_m) begin
         infl_m = 1'b0;
         done_m++;
      end
   endtask

   task automatic idle_bus();
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = '0;
      bus.wbs_dat_i = '0;
   endtask

   task automatic wb_cycle(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [3:0] sl, output logic [31:0] rdat);
      bit seen;
      seen = 1'b0;
      rdat = '0;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_we_i  = wr;
      bus.wbs_sel_i = sl;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wd;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) begin
            seen = 1'b1;
            rdat = bus.wbs_dat_o;
         end
      end
      idle_bus();
      check("wb_ack", {31'd0, seen}, 32'd1);
      @(negedge clk);
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sl);
      logic [31:0] dummy;
      wb_cycle(1'b1, adr, wd, sl, dummy);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
      wb_cycle(1'b0, adr, 32'h0, 4'hF, rdat);
   endtask

   initial begin
      logic [31:0] rd, w;
      logic [3:0]  sl;
      int          v_rises, r;
      logic        prev_v;
      bit          bad, seen;

      idle_bus();
      bus.cmd_ready_i = 1'b0;
      bus.core_done_i = 1'b0;
      infl_m = 1'b0; ovf_m = 1'b0; done_m = 0; last_m = '0; cur_m = '0;

      // outputs while reset is held
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
      check("rst_dat", bus.wbs_dat_o, 32'd0);
      check("rst_valid", {31'd0, bus.cmd_valid_o}, 32'd0);
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("rst_irq", {31'd0, bus.irq_o}, 32'd0);
      check("rst_payload", obs_payload(), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      wb_read(STA, rd);
      check("status_reset", rd, 32'h0000_0002);

      // unmapped address is never acked
      seen = 1'b0;
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = OPC + 32'd4;
      repeat (4) begin
         @(negedge clk);
         if (bus.wbs_ack_o) seen = 1'b1;
      end
      idle_bus();
      check("unmapped_ack", {31'd0, seen}, 32'd0);
      @(negedge clk);

      // strobe held for 5 cycles: exactly one push and one issue
      w = 32'h8323_2002;
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = OPC; bus.wbs_dat_i = w;
      v_rises = 0; prev_v = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("push_ack", {31'd0, bus.wbs_ack_o}, 32'd1);
            check("lat_push_edge", {31'd0, bus.cmd_valid_o}, 32'd0);
         end
         if (i == 1) check("lat_next_edge", {31'd0, bus.cmd_valid_o}, 32'd1);
         if (bus.cmd_valid_o && !prev_v) v_rises++;
         prev_v = bus.cmd_valid_o;
      end
      idle_bus();
      model_write(w, 4'hF);
      model_settle();
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.cmd_valid_o !== 1'b1 || obs_payload() !== exp_payload(cur_m)) bad = 1'b1;
         if (bus.cmd_valid_o && !prev_v) v_rises++;
         prev_v = bus.cmd_valid_o;
      end
      check("hold_stable", {31'd0, bad}, 32'd0);
      check("single_issue", 32'(v_rises), 32'd1);
      check("payload_fixed", obs_payload(), {3'b0, 9'd50, 9'd100, 9'd0, 2'd2});
      wb_read(OPC, rd);
      check("last_word", rd, last_m);
      wb_read(STA, rd);
      check("status_issue", rd, exp_status());

      // handshake -> WAIT
      bus.cmd_ready_i = 1'b1;
      @(negedge clk);
      bus.cmd_ready_i = 1'b0;
      check("accept_valid", {31'd0, bus.cmd_valid_o}, 32'd0);
      check("accept_busy", {31'd0, bus.busy_o}, 32'd1);

      // completion pulse
      bus.core_done_i = 1'b1;
      @(negedge clk);
      bus.core_done_i = 1'b0;
      check("irq_high", {31'd0, bus.irq_o}, 32'd1);
      model_done();
      @(negedge clk);
      check("irq_low", {31'd0, bus.irq_o}, 32'd0);
      check("idle_busy", {31'd0, bus.busy_o}, 32'd0);

      // done outside WAIT is ignored
      bus.core_done_i = 1'b1;
      @(negedge clk);
      bus.core_done_i = 1'b0;
      check("stray_done_irq", {31'd0, bus.irq_o}, 32'd0);
      wb_read(STA, rd);
      check("stray_done_status", rd, exp_status());

      // stalled core: 1 issued, 4 queued, 6th dropped
      for (int k = 0; k < 6; k++) begin
         w = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
         wb_write(OPC, w, 4'hF);
         model_write(w, 4'hF);
         @(negedge clk);
         model_settle();
      end
      wb_read(STA, rd);
      check("status_overflow", rd, exp_status());
      check("status_ovf_bits", rd & 32'h7F, 32'h4D);
      check("stalled_payload", obs_payload(), exp_payload(cur_m));
      wb_read(OPC, rd);
      check("last_after_drop", rd, last_m);
      wb_write(STA, 32'h8, 4'hF);
      ovf_m = 1'b0;
      wb_read(STA, rd);
      check("status_w1c", rd, exp_status());

      // accept, complete, next queued command issues
      bus.cmd_ready_i = 1'b1;
      @(negedge clk);
      bus.cmd_ready_i = 1'b0;
      bus.core_done_i = 1'b1;
      @(negedge clk);
      bus.core_done_i = 1'b0;
      check("irq_second", {31'd0, bus.irq_o}, 32'd1);
      model_done();
      @(negedge clk);
      model_settle();
      check("next_valid", {31'd0, bus.cmd_valid_o}, 32'd1);
      check("next_payload", obs_payload(), exp_payload(cur_m));
      wb_read(STA, rd);
      check("status_next", rd, exp_status());

      // refill to full, then push on the same edge as a pop
      w = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
      wb_write(OPC, w, 4'hF);
      model_write(w, 4'hF);
      bus.cmd_ready_i = 1'b1;
      @(negedge clk);
      bus.cmd_ready_i = 1'b0;
      bus.core_done_i = 1'b1;
      @(negedge clk);
      bus.core_done_i = 1'b0;
      model_done();
      w = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
      wb_write(OPC, w, 4'hF);
      model_settle();
      model_write(w, 4'hF);
      wb_read(STA, rd);
      check("status_push_pop_full", rd, exp_status());
      check("push_pop_payload", obs_payload(), exp_payload(cur_m));

      // randomized phase with ready held high
      bus.cmd_ready_i = 1'b1;
      @(negedge clk);
      for (int it = 0; it < 3000 && done_m < 300; it++) begin
         r = $urandom_range(0, 9);
         if (r < 5) begin
            w  = $urandom;
            w[31] = ($urandom_range(0, 4) != 0);
            sl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            wb_write(OPC, w, sl);
            model_write(w, sl);
            repeat (2) @(negedge clk);
            model_settle();
         end else if (r < 9) begin
            bus.core_done_i = 1'b1;
            @(negedge clk);
            bus.core_done_i = 1'b0;
            check("rnd_irq", {31'd0, bus.irq_o}, {31'd0, infl_m});
            model_done();
            repeat (2) @(negedge clk);
            model_settle();
            if (done_m == 256) begin
               wb_read(STA, rd);
               check("done_wrap", (rd >> 8) & 32'hFF, 32'd0);
            end
         end else begin
            wb_read(STA, rd);
            check("rnd_status", rd, exp_status());
            wb_read(OPC, rd);
            check("rnd_last", rd, last_m);
            w = $urandom;
            wb_write(STA, w, 4'hF);
            if (w[3]) ovf_m = 1'b0;
         end
         check("rnd_busy", {31'd0, bus.busy_o}, {31'd0, infl_m});
         if (infl_m) check("rnd_payload", obs_payload(), exp_payload(cur_m));
      end
      check("wrap_reached", {31'd0, done_m >= 300}, 32'd1);

      // drain, then 1 in WAIT + 3 queued, then reset mid-command
      for (int k = 0; k < 8 && (infl_m || mq.size() > 0); k++) begin
         bus.core_done_i = 1'b1;
         @(negedge clk);
         bus.core_done_i = 1'b0;
         model_done();
         repeat (2) @(negedge clk);
         model_settle();
      end
      for (int k = 0; k < 4; k++) begin
         w = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
         wb_write(OPC, w, 4'hF);
         model_write(w, 4'hF);
         repeat (2) @(negedge clk);
         model_settle();
      end
      wb_read(STA, rd);
      check("pre_reset_status", rd, exp_status());
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, bus.cmd_valid_o}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("midrst_payload", obs_payload(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete(); infl_m = 1'b0; ovf_m = 1'b0; done_m = 0; last_m = '0;
      @(negedge clk);
      wb_read(STA, rd);
      check("post_reset_status", rd, 32'h0000_0002);

      // start bit clear: acked, nothing queued
      w = $urandom & 32'h7FFF_FFFF;
      wb_write(OPC, w, 4'hF);
      model_write(w, 4'hF);
      repeat (2) @(negedge clk);
      check("nostart_valid", {31'd0, bus.cmd_valid_o}, 32'd0);
      wb_read(STA, rd);
      check("nostart_status", rd, exp_status());
      wb_read(OPC, rd);
      check("nostart_last", rd, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
